// File: rtl/fifo_ctrl_pkg.sv
// Shared defaults and derived widths for the FIFO controller and its pointer counters.
package fifo_ctrl_pkg;

  localparam int ADDR_WIDTH_DEF      = 4;
  localparam int ALMOST_FULL_TH_DEF  = 12;
  localparam int ALMOST_EMPTY_TH_DEF = 2;

  // Occupancy needs one extra bit so that a completely full FIFO (DEPTH) is representable.
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_ctrl_ptr_counter.sv
// Wrapping ADDR_WIDTH-bit pointer with increment enable; rolls over naturally at DEPTH.
module ptr_counter
  import fifo_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] ptr
);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO control beside the dual-port memoria: gates push/pop, drives addresses and enables,
// tracks occupancy, registers status/error flags and the read-data valid strobe.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
  parameter int DEPTH           = 1 << ADDR_WIDTH,
  parameter int ALMOST_FULL_TH  = ALMOST_FULL_TH_DEF,
  parameter int ALMOST_EMPTY_TH = ALMOST_EMPTY_TH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic                  pop,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] addressW,
  output logic [ADDR_WIDTH-1:0] addressR,
  output logic                  data_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW = count_width(ADDR_WIDTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_TH   = CW'(ALMOST_FULL_TH);
  localparam logic [CW-1:0] AE_TH   = CW'(ALMOST_EMPTY_TH);

  logic          push_ok;
  logic          pop_ok;
  logic [CW-1:0] count_nxt;

  // A pop frees a slot in the same cycle, so a push at full is still taken when paired with one.
  always_comb begin
    pop_ok    = pop & ~empty & reset_L;
    push_ok   = push & (~full | pop_ok) & reset_L;
    mem_write = push_ok;
    mem_read  = pop_ok;
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  ptr_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk     (clk),
    .reset_L (reset_L),
    .en      (push_ok),
    .ptr     (addressW)
  );

  ptr_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk     (clk),
    .reset_L (reset_L),
    .en      (pop_ok),
    .ptr     (addressR)
  );

  // Stage boundary: occupancy, flags from next count, valid aligned with memoria's registered read.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      data_valid   <= 1'b0;
    end else begin
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH_C);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_TH);
      almost_empty <= (count_nxt <= AE_TH);
      overflow     <= overflow  | (push & ~push_ok);
      underflow    <= underflow | (pop & empty);
      data_valid   <= pop_ok;
    end
  end

endmodule
